// File: rtl/w0rm_bus_pkg.sv
`default_nettype none
// w0rm_bus_pkg -- arbiter FSM state encoding, requester ids and id helpers. Rev 1.0
package w0rm_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  localparam logic ID_M0 = 1'b0;
  localparam logic ID_M1 = 1'b1;

  function automatic logic [1:0] id_onehot(input logic id);
    return (id == ID_M1) ? 2'b10 : 2'b01;
  endfunction

  function automatic logic other_id(input logic id);
    return (id == ID_M1) ? ID_M0 : ID_M1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/w0rm_rr_grant2.sv
`default_nettype none
// w0rm_rr_grant2 -- two-way round-robin grant: on contention the requester not served last wins. Rev 1.0
module w0rm_rr_grant2
  import w0rm_bus_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_id,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = id_onehot(other_id(last_id));
      default: grant = 2'b00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/w0rm_periph_arbiter.sv
`default_nettype none
// w0rm_periph_arbiter -- two requesters share one peripheral bus, one transaction in flight. Rev 1.0
// Define W0RM_ARB_TIMEOUT_EN to abort transactions that run for TIMEOUT_CYCLES without completing.
module w0rm_periph_arbiter
  import w0rm_bus_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  m0_valid_i,
  input  logic                  m0_write_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_data_i,
  output logic                  m0_ready_o,
  output logic                  m0_resp_valid_o,
  output logic [DATA_WIDTH-1:0] m0_resp_data_o,
  output logic                  m0_resp_err_o,

  input  logic                  m1_valid_i,
  input  logic                  m1_write_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_data_i,
  output logic                  m1_ready_o,
  output logic                  m1_resp_valid_o,
  output logic [DATA_WIDTH-1:0] m1_resp_data_o,
  output logic                  m1_resp_err_o,

  output logic                  s_valid_o,
  output logic                  s_write_o,
  output logic [ADDR_WIDTH-1:0] s_addr_o,
  output logic [DATA_WIDTH-1:0] s_data_o,
  input  logic                  s_ready_i,
  input  logic                  s_resp_valid_i,
  input  logic [DATA_WIDTH-1:0] s_resp_data_i
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("w0rm_periph_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  arb_state_e            state;
  logic                  last_id;
  logic                  gnt_id;
  logic [1:0]            grant;
  logic [1:0]            resp_valid;
  logic [1:0]            resp_err;
  logic [DATA_WIDTH-1:0] resp_data [2];
  logic                  idle_open;
  logic                  accept;
  logic                  done;
  logic                  timed_out;
  logic                  finish;

  w0rm_rr_grant2 u_grant (
    .valid   ({m1_valid_i, m0_valid_i}),
    .last_id (last_id),
    .grant   (grant)
  );

  // Ready is combinational so a request can transfer in the same cycle it is granted.
  assign idle_open  = (state == ST_IDLE) && !reset;
  assign m0_ready_o = idle_open && grant[0];
  assign m1_ready_o = idle_open && grant[1];
  assign accept     = m0_ready_o || m1_ready_o;

  // A response arriving together with the request handshake closes the transaction at once.
  assign done = ((state == ST_ISSUE) && s_ready_i && s_resp_valid_i) ||
                ((state == ST_WAIT)  && s_resp_valid_i);

`ifdef W0RM_ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] tmo_cnt;

  assign timed_out = (state != ST_IDLE) && !done && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || (state == ST_IDLE)) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end
`else
  assign timed_out = 1'b0;
`endif

  assign finish = done || timed_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      last_id      <= ID_M1;
      gnt_id       <= ID_M0;
      s_valid_o    <= 1'b0;
      s_write_o    <= 1'b0;
      s_addr_o     <= '0;
      s_data_o     <= '0;
      resp_valid   <= 2'b00;
      resp_err     <= 2'b00;
      resp_data[0] <= '0;
      resp_data[1] <= '0;
    end else begin
      resp_valid   <= 2'b00;
      resp_err     <= 2'b00;
      resp_data[0] <= '0;
      resp_data[1] <= '0;
      if (finish) begin
        state              <= ST_IDLE;
        s_valid_o          <= 1'b0;
        last_id            <= gnt_id;
        resp_valid[gnt_id] <= 1'b1;
        resp_err[gnt_id]   <= timed_out;
        resp_data[gnt_id]  <= done ? s_resp_data_i : '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (accept) begin
              gnt_id    <= grant[1] ? ID_M1 : ID_M0;
              s_write_o <= grant[1] ? m1_write_i : m0_write_i;
              s_addr_o  <= grant[1] ? m1_addr_i  : m0_addr_i;
              s_data_o  <= grant[1] ? m1_data_i  : m0_data_i;
              s_valid_o <= 1'b1;
              state     <= ST_ISSUE;
            end
          end
          ST_ISSUE: begin
            if (s_ready_i) begin
              s_valid_o <= 1'b0;
              state     <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            state <= ST_WAIT;
          end
          default: begin
            state     <= ST_IDLE;
            s_valid_o <= 1'b0;
          end
        endcase
      end
    end
  end

  assign m0_resp_valid_o = resp_valid[0];
  assign m1_resp_valid_o = resp_valid[1];
  assign m0_resp_err_o   = resp_err[0];
  assign m1_resp_err_o   = resp_err[1];
  assign m0_resp_data_o  = resp_data[0];
  assign m1_resp_data_o  = resp_data[1];

endmodule
`default_nettype wire

// File: tb/tb_w0rm_periph_arbiter.sv
`default_nettype none
// tb_w0rm_periph_arbiter -- directed and randomized checks of the two-requester peripheral arbiter. Rev 1.0
module tb_w0rm_periph_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  localparam int P_MANUAL = 0;
  localparam int P_ZERO   = 1;
  localparam int P_RAND   = 2;
  localparam int P_HANG   = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          m0_valid_i = 1'b0, m0_write_i = 1'b0;
  logic [AW-1:0] m0_addr_i = '0;
  logic [DW-1:0] m0_data_i = '0;
  logic          m0_ready_o, m0_resp_valid_o, m0_resp_err_o;
  logic [DW-1:0] m0_resp_data_o;
  logic          m1_valid_i = 1'b0, m1_write_i = 1'b0;
  logic [AW-1:0] m1_addr_i = '0;
  logic [DW-1:0] m1_data_i = '0;
  logic          m1_ready_o, m1_resp_valid_o, m1_resp_err_o;
  logic [DW-1:0] m1_resp_data_o;
  logic          s_valid_o, s_write_o;
  logic [AW-1:0] s_addr_o;
  logic [DW-1:0] s_data_o;
  logic          s_ready_i = 1'b0, s_resp_valid_i = 1'b0;
  logic [DW-1:0] s_resp_data_i = '0;

  w0rm_periph_arbiter #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .m0_valid_i      (m0_valid_i),
    .m0_write_i      (m0_write_i),
    .m0_addr_i       (m0_addr_i),
    .m0_data_i       (m0_data_i),
    .m0_ready_o      (m0_ready_o),
    .m0_resp_valid_o (m0_resp_valid_o),
    .m0_resp_data_o  (m0_resp_data_o),
    .m0_resp_err_o   (m0_resp_err_o),
    .m1_valid_i      (m1_valid_i),
    .m1_write_i      (m1_write_i),
    .m1_addr_i       (m1_addr_i),
    .m1_data_i       (m1_data_i),
    .m1_ready_o      (m1_ready_o),
    .m1_resp_valid_o (m1_resp_valid_o),
    .m1_resp_data_o  (m1_resp_data_o),
    .m1_resp_err_o   (m1_resp_err_o),
    .s_valid_o       (s_valid_o),
    .s_write_o       (s_write_o),
    .s_addr_o        (s_addr_o),
    .s_data_o        (s_data_o),
    .s_ready_i       (s_ready_i),
    .s_resp_valid_i  (s_resp_valid_i),
    .s_resp_data_i   (s_resp_data_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: one transaction outstanding, handed = peripheral took the request.
  bit          busy = 1'b0, handed = 1'b0, last_srv = 1'b1, gid = 1'b0;
  bit          req_w;
  logic [AW-1:0] req_a;
  logic [DW-1:0] req_d;
  int          busy_cnt = 0;
  bit          rdue = 1'b0, rid = 1'b0, rerr = 1'b0;
  logic [DW-1:0] rdat = '0;

  int          pmode = P_MANUAL;
  bit          rand_masters = 1'b0;
  bit          pend [2] = '{1'b0, 1'b0};
  bit          pw   [2];
  logic [31:0] pa   [2];
  logic [31:0] pd   [2];

  int acc_cnt   [2] = '{0, 0};
  int abandoned [2] = '{0, 0};
  int rsp_obs   [2] = '{0, 0};
  int err_obs   = 0;
  int acc_cyc   = 0;
  int obs_lat   = -1;
  int obs_grants[$];

  function automatic bit [1:0] oh(input bit id);
    return id ? 2'b10 : 2'b01;
  endfunction

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit [1:0] vv;
    bit [1:0] exp_rdy;
    bit       win;
    bit       fin_ok;
    bit       fin_to;
    if (rand_masters) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && ($urandom_range(0, 2) == 0)) begin
          pend[i] = 1'b1;
          pw[i]   = 1'($urandom_range(0, 1));
          pa[i]   = $urandom;
          pd[i]   = $urandom;
        end
      end
      m0_valid_i = pend[0]; m0_write_i = pw[0]; m0_addr_i = pa[0]; m0_data_i = pd[0];
      m1_valid_i = pend[1]; m1_write_i = pw[1]; m1_addr_i = pa[1]; m1_data_i = pd[1];
    end
    case (pmode)
      P_ZERO: begin
        s_ready_i      = busy && !handed;
        s_resp_valid_i = busy && handed;
        s_resp_data_i  = $urandom;
      end
      P_RAND: begin
        s_ready_i     = 1'($urandom_range(0, 1));
        s_resp_data_i = $urandom;
        if (!busy)        s_resp_valid_i = ($urandom_range(0, 9) == 0);
        else if (!handed) s_resp_valid_i = s_ready_i && ($urandom_range(0, 2) == 0);
        else              s_resp_valid_i = ($urandom_range(0, 2) == 0);
      end
      P_HANG: begin
        s_ready_i      = busy && !handed;
        s_resp_valid_i = 1'b0;
      end
      default: ;
    endcase
    #1;
    chk("resp_valid", {m1_resp_valid_o, m0_resp_valid_o}, rdue ? oh(rid) : 2'b00);
    chk("resp_err", {m1_resp_err_o, m0_resp_err_o}, (rdue && rerr) ? oh(rid) : 2'b00);
    chk("m0_resp_data", m0_resp_data_o, (rdue && !rid) ? rdat : '0);
    chk("m1_resp_data", m1_resp_data_o, (rdue && rid) ? rdat : '0);
    vv      = {m1_valid_i, m0_valid_i};
    exp_rdy = 2'b00;
    if (!busy) exp_rdy = (vv == 2'b11) ? oh(!last_srv) : vv;
    chk("ready", {m1_ready_o, m0_ready_o}, exp_rdy);
    chk("s_valid", s_valid_o, busy && !handed);
    if (busy && !handed) chk("s_request", {s_write_o, s_addr_o, s_data_o}, {req_w, req_a, req_d});
    if ({m1_ready_o, m0_ready_o} != 2'b00) obs_grants.push_back(int'(m1_ready_o));
    if (m0_resp_valid_o) rsp_obs[0]++;
    if (m1_resp_valid_o) rsp_obs[1]++;
    if (m0_resp_valid_o || m1_resp_valid_o) obs_lat = cyc - acc_cyc;
    if (m0_resp_err_o || m1_resp_err_o) err_obs++;
    rdue = 1'b0;
    if (!busy) begin
      if (exp_rdy != 2'b00) begin
        win      = exp_rdy[1];
        gid      = win;
        req_w    = win ? m1_write_i : m0_write_i;
        req_a    = win ? m1_addr_i  : m0_addr_i;
        req_d    = win ? m1_data_i  : m0_data_i;
        busy     = 1'b1;
        handed   = 1'b0;
        busy_cnt = 0;
        acc_cnt[win]++;
        acc_cyc  = cyc;
        if (rand_masters) pend[win] = 1'b0;
      end
    end else begin
      fin_ok = handed ? s_resp_valid_i : (s_ready_i && s_resp_valid_i);
      fin_to = 1'b0;
`ifdef W0RM_ARB_TIMEOUT_EN
      fin_to = !fin_ok && (busy_cnt == TO - 1);
`endif
      if (fin_ok || fin_to) begin
        busy     = 1'b0;
        last_srv = gid;
        rdue     = 1'b1;
        rid      = gid;
        rerr     = fin_to;
        rdat     = fin_ok ? s_resp_data_i : '0;
      end else if (!handed && s_ready_i) begin
        handed = 1'b1;
      end
      busy_cnt++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("ready_in_reset", {m1_ready_o, m0_ready_o}, 2'b00);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc++;
    if (busy) abandoned[gid]++;
    busy     = 1'b0;
    handed   = 1'b0;
    rdue     = 1'b0;
    last_srv = 1'b1;
    chk("rst_s_valid", s_valid_o, 1'b0);
    chk("rst_s_write", s_write_o, 1'b0);
    chk("rst_s_addr", s_addr_o, '0);
    chk("rst_s_data", s_data_o, '0);
    chk("rst_resp_valid", {m1_resp_valid_o, m0_resp_valid_o}, 2'b00);
    chk("rst_resp_err", {m1_resp_err_o, m0_resp_err_o}, 2'b00);
    chk("rst_m0_resp_data", m0_resp_data_o, '0);
    chk("rst_m1_resp_data", m1_resp_data_o, '0);
  endtask

  initial begin
    int base0;
    int base1;

    do_reset();
    tick();

    // Single read with zero-wait peripheral.
    m0_valid_i = 1'b1; m0_write_i = 1'b0; m0_addr_i = 32'h10; m0_data_i = '0;
    obs_lat = -1;
    tick();
    m0_valid_i = 1'b0; s_ready_i = 1'b1;
    tick();
    s_ready_i = 1'b0; s_resp_valid_i = 1'b1; s_resp_data_i = 32'hA5A5_A5A5;
    tick();
    s_resp_valid_i = 1'b0;
    tick();
    chk("read_latency", obs_lat, 3);
    tick();

    // Same-cycle ready and response skips the wait phase.
    base0 = rsp_obs[0];
    m0_valid_i = 1'b1; m0_write_i = 1'b1; m0_addr_i = 32'h20; m0_data_i = 32'h55;
    obs_lat = -1;
    tick();
    m0_valid_i = 1'b0; s_ready_i = 1'b1; s_resp_valid_i = 1'b1; s_resp_data_i = 32'hDEAD_0001;
    tick();
    s_ready_i = 1'b0; s_resp_valid_i = 1'b0;
    tick();
    chk("same_cycle_latency", obs_lat, 2);
    tick();
    tick();
    chk("same_cycle_once", rsp_obs[0] - base0, 1);

    // Backpressure: request held stable for five stalled cycles, accepted once.
    base1 = acc_cnt[1];
    m1_valid_i = 1'b1; m1_write_i = 1'b0; m1_addr_i = 32'h1234_5670; m1_data_i = 32'hCAFE_F00D;
    tick();
    repeat (5) tick();
    m1_valid_i = 1'b0; s_ready_i = 1'b1;
    tick();
    s_ready_i = 1'b0; s_resp_valid_i = 1'b1; s_resp_data_i = 32'h0BAD_BEEF;
    tick();
    s_resp_valid_i = 1'b0;
    tick();
    chk("backpressure_single_accept", acc_cnt[1] - base1, 1);
    tick();

    // Contention from reset: grants alternate starting with m0.
    do_reset();
    obs_grants.delete();
    base0 = rsp_obs[0];
    base1 = rsp_obs[1];
    pmode = P_ZERO;
    m0_valid_i = 1'b1; m0_addr_i = 32'h100; m0_data_i = 32'h1;
    m1_valid_i = 1'b1; m1_addr_i = 32'h200; m1_data_i = 32'h2;
    repeat (12) tick();
    m0_valid_i = 1'b0; m1_valid_i = 1'b0;
    repeat (5) tick();
    chk("grant_count", obs_grants.size(), 4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("grant_%0d", k), (k < obs_grants.size()) ? obs_grants[k] : 9, k % 2);
    chk("contention_m0_resps", rsp_obs[0] - base0, 2);
    chk("contention_m1_resps", rsp_obs[1] - base1, 2);

    // Peripheral that never responds.
    pmode = P_HANG;
    m1_valid_i = 1'b1; m1_write_i = 1'b0; m1_addr_i = 32'h300;
    tick();
    m1_valid_i = 1'b0;
    repeat (20) tick();
`ifdef W0RM_ARB_TIMEOUT_EN
    chk("timeout_err_strobes", err_obs, 1);
`else
    chk("no_timeout_err", err_obs, 0);
    chk("no_timeout_resp", {m1_resp_valid_o, m0_resp_valid_o}, 2'b00);
    do_reset();
`endif
    pmode = P_MANUAL; s_ready_i = 1'b0; s_resp_valid_i = 1'b1; s_resp_data_i = 32'h7777_7777;
    repeat (2) tick();
    s_resp_valid_i = 1'b0;
    tick();

    // Reset while waiting for a response.
    m1_valid_i = 1'b1; m1_addr_i = 32'h400;
    tick();
    m1_valid_i = 1'b0; s_ready_i = 1'b1;
    tick();
    s_ready_i = 1'b0;
    tick();
    do_reset();
    s_resp_valid_i = 1'b1; s_resp_data_i = 32'h1111_2222;
    tick();
    s_resp_valid_i = 1'b0;
    obs_grants.delete();
    m0_valid_i = 1'b1; m1_valid_i = 1'b1;
    tick();
    chk("post_reset_grant_m0", (obs_grants.size() > 0) ? obs_grants[0] : 9, 0);
    m0_valid_i = 1'b0; m1_valid_i = 1'b0;
    pmode = P_ZERO;
    repeat (5) tick();

    // Randomized traffic against the reference model.
    rand_masters = 1'b1;
    pmode = P_RAND;
    repeat (400) tick();
    rand_masters = 1'b0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    m0_valid_i = 1'b0; m1_valid_i = 1'b0;
    pmode = P_ZERO;
    repeat (8) tick();

    chk("scoreboard_m0", rsp_obs[0], acc_cnt[0] - abandoned[0]);
    chk("scoreboard_m1", rsp_obs[1], acc_cnt[1] - abandoned[1]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
